divider_16bit: RTL



---
 rtl/divider_16bit_pkg.sv | 16 +
 rtl/divider_16bit_step.sv | 37 +++
 rtl/divider_16bit.sv | 95 +++++++++
 3 files changed

// File: rtl/divider_16bit_pkg.sv
// Shared constants and types for the 16-bit restoring divider.
//   WIDTH    : operand/result width; also the number of iterations
//   CNT_W    : width of the step counter
//   state_t  : controller state encoding
package divider_16bit_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : divider_16bit_pkg

// File: rtl/divider_16bit_step.sv
// One restoring-division step: trial subtraction of the divisor from the
// shifted partial remainder, built as a WIDTH+1-bit ripple chain of full
// adders with the divisor inverted and carry-in forced to 1.
//   r_shifted : partial remainder after the left shift (WIDTH+1 bits)
//   d         : divisor
//   r_next_c  : restored or reduced partial remainder
//   q_bit_c   : quotient bit produced by this step
module divider_16bit_step
    import divider_16bit_pkg::*;
(
    input  logic [WIDTH:0]   r_shifted,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] b_inv;
    logic [WIDTH:0] diff;

    assign b_inv = ~{1'b0, d};

    // Ripple chain of full-adder cells: sum = a^b^c, carry = ab | c(a^b).
    always_comb begin
        logic c;
        c    = 1'b1;
        diff = '0;
        for (int i = 0; i <= int'(WIDTH); i++) begin
            diff[i] = r_shifted[i] ^ b_inv[i] ^ c;
            c       = (r_shifted[i] & b_inv[i]) | (c & (r_shifted[i] ^ b_inv[i]));
        end
    end

    // A clear sign bit means the trial result is non-negative: keep it.
    assign q_bit_c  = ~diff[WIDTH];
    assign r_next_c = q_bit_c ? diff : r_shifted;

endmodule : divider_16bit_step

// File: rtl/divider_16bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : accept dividend/divisor (in IDLE or DONE)
//   dividend, divisor   : operands, sampled with start
//   busy                : division in progress
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next completion
//   div_by_zero         : latched divisor was zero, held with the results
module divider_16bit
    import divider_16bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   r_shifted;
    logic [WIDTH:0]   r_next;
    logic             q_bit;

    // {R,Q} << 1: the MSB of Q enters the LSB of R.
    assign r_shifted = (r_reg << 1) | (WIDTH + 1)'(q_reg[WIDTH-1]);

    divider_16bit_step u_step (
        .r_shifted (r_shifted),
        .d         (d_reg),
        .r_next_c  (r_next),
        .q_bit_c   (q_bit)
    );

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    q_reg <= {q_reg[WIDTH-2:0], q_bit};
                    r_reg <= r_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        quotient    <= {q_reg[WIDTH-2:0], q_bit};
                        remainder   <= r_next[WIDTH-1:0];
                        div_by_zero <= (d_reg == '0);
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : divider_16bit
